// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   16x-oversampling UART receiver with majority-vote bit sampling, a framing
//   check and a receive FIFO that the consumer drains with a rd strobe.
//   With UART_RX_PARITY_EN defined, the frame is 8E1 and parity_err is live.
//   Without it, the frame is 8N1 and parity_err is tied 0.
//
// Ports
//   clk        system clock
//   resetq     asynchronous reset, active low
//   rx         serial line, idle high, asynchronous to clk
//   rd         pop strobe, honoured only while valid=1
//   valid      FIFO non-empty
//   data       FIFO head byte
//   level      FIFO occupancy 0..FIFO_DEPTH
//   frame_err  sticky: stop bit sampled low
//   overrun    sticky: byte completed into a full FIFO with no pop
//   parity_err sticky: parity mismatch
//   clr_err    clears all sticky flags (a set event in the same cycle wins)
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | line idle, waiting for a synced 1->0 edge
// START   | validating the start bit; a high majority rejects it as a glitch
// DATA    | shifting in 8 data bits, LSB first
// PARITY  | sampling the even-parity bit (parity build only)
// STOP    | sampling the stop bit; push, discard or flag the byte
// BREAK   | line low after a framing error; wait for it to go high
module uart_rx_fifo #(
    parameter int CLKFREQ    = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16,
    localparam int L         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic         clk,
    input  logic         resetq,
    input  logic         rx,
    input  logic         rd,
    output logic         valid,
    output logic [7:0]   data,
    output logic [L-1:0] level,
    output logic         frame_err,
    output logic         overrun,
    output logic         parity_err,
    input  logic         clr_err
);

    localparam int DIV = CLKFREQ / (16 * BAUD);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
    } state_t;

    state_t        state;
    logic          rx_s1, rx_s2, rx_prev;
    logic [TW-1:0] tick_cnt;
    logic [3:0]    s;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          v7, v8;
    logic          tick, start_edge, dec, wrap, bit_val;
    logic          push_evt, frame_evt;

    // The edge history resets to 0, so the line must be observed high
    // before a falling edge can count as a start bit.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b0;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign start_edge = rx_prev & ~rx_s2;
    assign tick       = (tick_cnt == TW'(DIV - 1));

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq)
            tick_cnt <= '0;
        else if ((state == ST_IDLE && start_edge) || tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + TW'(1);
    end

    assign dec     = tick && (s == 4'd9);
    assign wrap    = tick && (s == 4'd15);
    assign bit_val = (v7 & v8) | (v7 & rx_s2) | (v8 & rx_s2);

`ifdef UART_RX_PARITY_EN
    logic par_bad;
    logic par_evt;
    assign push_evt = (state == ST_STOP) && dec && bit_val && !par_bad;
    assign par_evt  = (state == ST_STOP) && dec && bit_val && par_bad;
`else
    assign push_evt   = (state == ST_STOP) && dec && bit_val;
    assign parity_err = 1'b0;
`endif
    assign frame_evt = (state == ST_STOP) && dec && !bit_val;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state     <= ST_IDLE;
            s         <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            v7        <= 1'b0;
            v8        <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            if (tick && s == 4'd7) v7 <= rx_s2;
            if (tick && s == 4'd8) v8 <= rx_s2;

            if (state == ST_IDLE)
                s <= '0;
            else if (tick)
                s <= s + 4'd1;

            frame_err <= frame_evt | (frame_err & ~clr_err);
`ifdef UART_RX_PARITY_EN
            parity_err <= par_evt | (parity_err & ~clr_err);
`endif

            case (state)
                ST_IDLE: begin
                    if (start_edge) state <= ST_START;
                end
                ST_START: begin
                    if (dec && bit_val)
                        state <= ST_IDLE;
                    else if (wrap) begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                        par_bad <= 1'b0;
`endif
                    end
                end
                ST_DATA: begin
                    if (dec) shreg <= {bit_val, shreg[7:1]};
                    if (wrap) begin
                        if (bit_cnt == 3'd7)
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        else
                            bit_cnt <= bit_cnt + 3'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    // Even parity: data bits plus parity bit must XOR to 0.
                    if (dec) par_bad <= ^{shreg, bit_val};
                    if (wrap) state <= ST_STOP;
                end
`endif
                ST_STOP: begin
                    // Decide mid stop bit so a following start edge is not missed.
                    if (dec) state <= bit_val ? ST_IDLE : ST_BREAK;
                end
                ST_BREAK: begin
                    if (rx_s2) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic          pop, full, do_write;

    assign valid    = (level != '0);
    assign full     = (level == L'(FIFO_DEPTH));
    assign pop      = rd && valid;
    assign do_write = push_evt && (!full || pop);
    assign data     = mem[rptr];

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wptr    <= '0;
            rptr    <= '0;
            level   <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_write) begin
                mem[wptr] <= shreg;
                wptr      <= wptr + AW'(1);
            end
            if (pop) rptr <= rptr + AW'(1);
            case ({do_write, pop})
                2'b10:   level <= level + L'(1);
                2'b01:   level <= level - L'(1);
                default: level <= level;
            endcase
            overrun <= (push_evt && full && !pop) | (overrun & ~clr_err);
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    localparam int CLKFREQ = 16000000;
    localparam int BAUD    = 1000000;
    localparam int DEPTH   = 16;
    localparam int L       = $clog2(DEPTH) + 1;
`ifdef UART_RX_PARITY_EN
    localparam int STOP_IDX = 10;
`else
    localparam int STOP_IDX = 9;
`endif
    // Negedges from the start-bit negedge to the one just before the
    // stop-bit decision edge (2 sync + 1 detect + 16*STOP_IDX + 9 samples).
    localparam int PUSH_NEG = 16 * STOP_IDX + 12;

    logic         clk = 1'b0;
    logic         resetq, rx, rd, clr_err;
    logic         valid;
    logic [7:0]   data;
    logic [L-1:0] level;
    logic         frame_err, overrun, parity_err;

    int n_cmp = 0;
    int n_err = 0;

    uart_rx_fifo #(.CLKFREQ(CLKFREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .resetq(resetq), .rx(rx), .rd(rd), .valid(valid), .data(data),
        .level(level), .frame_err(frame_err), .overrun(overrun),
        .parity_err(parity_err), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    // Called on a negedge; each bit is held for 16 clocks.
    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            rx = bits[i];
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
`ifdef UART_RX_PARITY_EN
        send_bits({stop, ^b, b, 1'b0}, 11);
`else
        send_bits({1'b0, stop, b, 1'b0}, 10);
`endif
    endtask

    task automatic pop_byte(output logic [7:0] d);
        d  = data;
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    task automatic test_reset();
        resetq = 1'b0; rx = 1'b1; rd = 1'b0; clr_err = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid); end
        n_cmp++; if (level !== '0) begin n_err++; $display("FAIL reset_level: got %0d want 0", level); end
        n_cmp++; if (data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", data); end
        n_cmp++; if ({frame_err, overrun, parity_err} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {frame_err, overrun, parity_err}); end
        resetq = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        send_frame(8'h55, 1'b1);
        send_frame(8'hA3, 1'b1);
        repeat (4) @(negedge clk);
        n_cmp++; if (level !== L'(2)) begin n_err++; $display("FAIL b2b_level: got %0d want 2", level); end
        pop_byte(d);
        n_cmp++; if (d !== 8'h55) begin n_err++; $display("FAIL b2b_first: got %h want 55", d); end
        pop_byte(d);
        n_cmp++; if (d !== 8'hA3) begin n_err++; $display("FAIL b2b_second: got %h want a3", d); end
        n_cmp++; if (level !== '0) begin n_err++; $display("FAIL b2b_empty: got %0d want 0", level); end
        n_cmp++; if ({frame_err, overrun, parity_err} !== 3'b000) begin n_err++; $display("FAIL b2b_flags: got %b want 000", {frame_err, overrun, parity_err}); end
    endtask

    task automatic test_glitch();
        logic [7:0] d;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        n_cmp++; if (level !== '0) begin n_err++; $display("FAIL glitch_level: got %0d want 0", level); end
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL glitch_frame_err: got %b want 0", frame_err); end
        send_frame(8'h3C, 1'b1);
        repeat (4) @(negedge clk);
        n_cmp++; if (level !== L'(1)) begin n_err++; $display("FAIL glitch_next_level: got %0d want 1", level); end
        pop_byte(d);
        n_cmp++; if (d !== 8'h3C) begin n_err++; $display("FAIL glitch_next_data: got %h want 3c", d); end
    endtask

    task automatic test_frame_err();
        logic [7:0] d;
        send_frame(8'h81, 1'b0);
        repeat (20 * 16) @(negedge clk);
        n_cmp++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL ferr_set: got %b want 1", frame_err); end
        n_cmp++; if (level !== '0) begin n_err++; $display("FAIL ferr_level: got %0d want 0", level); end
        pulse_clr();
        repeat (20 * 16) @(negedge clk);
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL ferr_once: got %b want 0", frame_err); end
        rx = 1'b1;
        repeat (32) @(negedge clk);
        send_frame(8'h42, 1'b1);
        repeat (4) @(negedge clk);
        n_cmp++; if (level !== L'(1)) begin n_err++; $display("FAIL ferr_next_level: got %0d want 1", level); end
        pop_byte(d);
        n_cmp++; if (d !== 8'h42) begin n_err++; $display("FAIL ferr_next_data: got %h want 42", d); end
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL ferr_after: got %b want 0", frame_err); end
    endtask

    task automatic test_overrun();
        logic [7:0] d;
        for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1);
        repeat (4) @(negedge clk);
        n_cmp++; if (level !== L'(16)) begin n_err++; $display("FAIL ovr_level: got %0d want 16", level); end
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %b want 1", overrun); end
        pulse_clr();
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clr: got %b want 0", overrun); end
        for (int i = 0; i < 16; i++) begin
            pop_byte(d);
            n_cmp++; if (d !== 8'(i)) begin n_err++; $display("FAIL ovr_pop%0d: got %h want %h", i, d, 8'(i)); end
        end
        n_cmp++; if (level !== '0) begin n_err++; $display("FAIL ovr_drained: got %0d want 0", level); end

        for (int i = 0; i < 16; i++) send_frame(8'h20 + 8'(i), 1'b1);
        fork
            send_frame(8'h30, 1'b1);
            begin
                repeat (PUSH_NEG) @(negedge clk);
                rd = 1'b1;
                @(negedge clk);
                rd = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        n_cmp++; if (level !== L'(16)) begin n_err++; $display("FAIL ovr_pushpop_level: got %0d want 16", level); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_pushpop_flag: got %b want 0", overrun); end
        n_cmp++; if (data !== 8'h21) begin n_err++; $display("FAIL ovr_pushpop_head: got %h want 21", data); end

        // Overrun set in the same cycle as clr_err must survive.
        fork
            send_frame(8'h31, 1'b1);
            begin
                repeat (PUSH_NEG) @(negedge clk);
                clr_err = 1'b1;
                @(negedge clk);
                clr_err = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set_wins: got %b want 1", overrun); end
        n_cmp++; if (data !== 8'h21) begin n_err++; $display("FAIL ovr_untouched: got %h want 21", data); end
        pulse_clr();
        for (int i = 0; i < 16; i++) begin
            pop_byte(d);
            n_cmp++; if (d !== 8'h21 + 8'(i)) begin n_err++; $display("FAIL ovr_pop2_%0d: got %h want %h", i, d, 8'h21 + 8'(i)); end
        end
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL ovr_final_valid: got %b want 0", valid); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        send_frame(8'h03, 1'b1);
        repeat (4) @(negedge clk);
        n_cmp++; if (level !== L'(3)) begin n_err++; $display("FAIL rst_pre_level: got %0d want 3", level); end
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        resetq = 1'b0;
        repeat (3) @(negedge clk);
        resetq = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b want 0", valid); end
        n_cmp++; if (level !== '0) begin n_err++; $display("FAIL rst_mid_level: got %0d want 0", level); end
        n_cmp++; if (data !== 8'h00) begin n_err++; $display("FAIL rst_mid_data: got %h want 00", data); end
        repeat (40) @(negedge clk);
        n_cmp++; if (level !== '0) begin n_err++; $display("FAIL rst_no_ghost: got %0d want 0", level); end
        send_frame(8'h12, 1'b1);
        repeat (4) @(negedge clk);
        n_cmp++; if (level !== L'(1)) begin n_err++; $display("FAIL rst_next_level: got %0d want 1", level); end
        pop_byte(d);
        n_cmp++; if (d !== 8'h12) begin n_err++; $display("FAIL rst_next_data: got %h want 12", d); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        logic [7:0] d;
        send_bits({1'b1, 1'b1, 8'h07, 1'b0}, 11);
        repeat (4) @(negedge clk);
        n_cmp++; if (level !== L'(1)) begin n_err++; $display("FAIL par_good_level: got %0d want 1", level); end
        n_cmp++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL par_good_flag: got %b want 0", parity_err); end
        pop_byte(d);
        n_cmp++; if (d !== 8'h07) begin n_err++; $display("FAIL par_good_data: got %h want 07", d); end
        send_bits({1'b1, 1'b0, 8'h07, 1'b0}, 11);
        repeat (4) @(negedge clk);
        n_cmp++; if (parity_err !== 1'b1) begin n_err++; $display("FAIL par_bad_flag: got %b want 1", parity_err); end
        n_cmp++; if (level !== '0) begin n_err++; $display("FAIL par_bad_level: got %0d want 0", level); end
        pulse_clr();
        n_cmp++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL par_clr: got %b want 0", parity_err); end
    endtask
`else
    task automatic test_parity();
        n_cmp++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL par_tied: got %b want 0", parity_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_reset_mid_frame();
        test_parity();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
